// File: rtl/bsg_manycore_cache_non_blocking_flow_ctrl_pkg.sv
// rtl/bsg_manycore_cache_non_blocking_flow_ctrl_pkg.sv - shared sizing helpers for the flow-control slice
//
// Purpose: default parameter values and width helpers used by the flow
// controller and its response FIFO. No new data types: the cache packet and
// the response id stay opaque vectors.
// Ports: none (package).

package bsg_manycore_cache_non_blocking_flow_ctrl_pkg;

  localparam int flow_ctrl_data_width_lp      = 32;
  localparam int flow_ctrl_id_width_lp        = 14;
  localparam int flow_ctrl_cache_pkt_width_lp = 80;
  localparam int flow_ctrl_els_lp             = 8;

  // Pointer width for a circular buffer of els entries (at least one bit).
  function automatic int flow_ctrl_ptr_width(input int els);
    return (els <= 2) ? 1 : $clog2(els);
  endfunction

  // Width of a counter that must be able to hold the value els itself.
  function automatic int flow_ctrl_cnt_width(input int els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bsg_manycore_cache_resp_fifo.sv
// rtl/bsg_manycore_cache_resp_fifo.sv - circular response buffer with registered head output
//
// Purpose: stores {data, id} cache responses in arrival order. Depth els_p
// need not be a power of two; both pointers wrap explicitly at els_p-1.
// The head entry is read straight out of the storage registers, so an entry
// written in cycle N is visible on data_o/v_o in cycle N+1.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   data_i, v_i      enqueue data and enqueue strobe
//   data_o, v_o      head entry and "not empty"
//   yumi_i           consume the head entry (only when v_o = 1)
//   empty_o, full_o  occupancy flags

module bsg_manycore_cache_resp_fifo
  import bsg_manycore_cache_non_blocking_flow_ctrl_pkg::*;
  #(
    parameter int width_p = flow_ctrl_data_width_lp + flow_ctrl_id_width_lp,
    parameter int els_p   = flow_ctrl_els_lp
  )
  (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    output logic               empty_o,
    output logic               full_o
  );

  localparam int ptr_width_lp = flow_ctrl_ptr_width(els_p);
  localparam int cnt_width_lp = flow_ctrl_cnt_width(els_p);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] els_cnt_lp  = cnt_width_lp'(els_p);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] rptr_r, wptr_r;
  logic [cnt_width_lp-1:0] count_r;

  logic [ptr_width_lp-1:0] rptr_next, wptr_next;

  assign rptr_next = (rptr_r == last_ptr_lp) ? '0 : rptr_r + 1'b1;
  assign wptr_next = (wptr_r == last_ptr_lp) ? '0 : wptr_r + 1'b1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (v_i)    wptr_r <= wptr_next;
      if (yumi_i) rptr_r <= rptr_next;
      case ({v_i, yumi_i})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: only entries between rptr and wptr are ever read.
  always_ff @(posedge clk_i) begin
    if (v_i && !reset_i) mem_r[wptr_r] <= data_i;
  end

  assign data_o  = mem_r[rptr_r];
  assign empty_o = (count_r == '0);
  assign full_o  = (count_r == els_cnt_lp);
  assign v_o     = ~empty_o;

  assert property (@(posedge clk_i) disable iff (reset_i) !(v_i && full_o));
  assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && empty_o));

endmodule

// File: rtl/bsg_manycore_cache_non_blocking_flow_ctrl.sv
// rtl/bsg_manycore_cache_non_blocking_flow_ctrl.sv - credit-gated request path and buffered response path
//
// Purpose: sits between the manycore link adapter and the non-blocking
// vcache. Requests pass through unchanged but are gated by an outstanding
// credit counter; every credit reserves one response FIFO slot, so cache
// responses are always accepted on arrival and a stalled link never
// back-pressures the cache pipeline. Credits return when the adapter
// consumes a response, not when the cache returns it.
// Optional feature: define BSG_MANYCORE_CACHE_FLOW_CTRL_BYPASS_EN to let a
// response arriving at an empty FIFO drive resp_*_o in the same cycle.
// Ports:
//   clk_i, reset_i                      clock, synchronous active-high reset
//   req_pkt_i, req_v_i, req_ready_o     request from adapter
//   cache_pkt_o, cache_v_o, cache_ready_i   request to cache
//   cache_data_i, cache_id_i, cache_v_i, cache_yumi_o  response from cache
//   resp_data_o, resp_id_o, resp_v_o, resp_yumi_i      response to adapter

module bsg_manycore_cache_non_blocking_flow_ctrl
  import bsg_manycore_cache_non_blocking_flow_ctrl_pkg::*;
  #(
    parameter int data_width_p      = flow_ctrl_data_width_lp,
    parameter int id_width_p        = flow_ctrl_id_width_lp,
    parameter int cache_pkt_width_p = flow_ctrl_cache_pkt_width_lp,
    parameter int els_p             = flow_ctrl_els_lp
  )
  (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic [cache_pkt_width_p-1:0] req_pkt_i,
    input  logic                         req_v_i,
    output logic                         req_ready_o,

    output logic [cache_pkt_width_p-1:0] cache_pkt_o,
    output logic                         cache_v_o,
    input  logic                         cache_ready_i,

    input  logic [data_width_p-1:0]      cache_data_i,
    input  logic [id_width_p-1:0]        cache_id_i,
    input  logic                         cache_v_i,
    output logic                         cache_yumi_o,

    output logic [data_width_p-1:0]      resp_data_o,
    output logic [id_width_p-1:0]        resp_id_o,
    output logic                         resp_v_o,
    input  logic                         resp_yumi_i
  );

  localparam int entry_width_lp = data_width_p + id_width_p;
  localparam int cnt_width_lp   = flow_ctrl_cnt_width(els_p);
  localparam logic [cnt_width_lp-1:0] els_cnt_lp = cnt_width_lp'(els_p);

  logic [cnt_width_lp-1:0] outstanding_r;
  logic                    credit_avail;
  logic                    issue;
  logic                    dequeue;

  logic [entry_width_lp-1:0] fifo_data_in, fifo_data_out, resp_entry;
  logic                      fifo_enq, fifo_deq;
  logic                      fifo_v, fifo_empty, fifo_full;

  // Request path: pure pass-through, gated only by credits.
  assign credit_avail = (outstanding_r != els_cnt_lp);
  assign cache_pkt_o  = req_pkt_i;
  assign cache_v_o    = req_v_i & credit_avail & ~reset_i;
  assign req_ready_o  = cache_ready_i & credit_avail & ~reset_i;
  assign issue        = cache_v_o & cache_ready_i;

  // Responses are never refused; credits guarantee a free slot.
  assign cache_yumi_o = cache_v_i;
  assign fifo_data_in = {cache_data_i, cache_id_i};

`ifdef BSG_MANYCORE_CACHE_FLOW_CTRL_BYPASS_EN
  // With an empty FIFO the arriving response is shown directly; if it is
  // consumed in the same cycle it never occupies a FIFO slot.
  assign resp_v_o   = fifo_v | cache_v_i;
  assign resp_entry = fifo_empty ? fifo_data_in : fifo_data_out;
  assign fifo_enq   = cache_v_i & ~(fifo_empty & resp_yumi_i);
  assign fifo_deq   = resp_yumi_i & ~fifo_empty;
`else
  assign resp_v_o   = fifo_v;
  assign resp_entry = fifo_data_out;
  assign fifo_enq   = cache_v_i;
  assign fifo_deq   = resp_yumi_i;
`endif

  assign resp_data_o = resp_entry[entry_width_lp-1:id_width_p];
  assign resp_id_o   = resp_entry[id_width_p-1:0];
  assign dequeue     = resp_v_o & resp_yumi_i;

  bsg_manycore_cache_resp_fifo #(
    .width_p (entry_width_lp),
    .els_p   (els_p)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (fifo_data_in),
    .v_i     (fifo_enq),
    .data_o  (fifo_data_out),
    .v_o     (fifo_v),
    .yumi_i  (fifo_deq),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Decrement on dequeue (not on cache return) so credits cover FIFO occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      outstanding_r <= '0;
    end else begin
      case ({issue, dequeue})
        2'b10:   outstanding_r <= outstanding_r + 1'b1;
        2'b01:   outstanding_r <= outstanding_r - 1'b1;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (reset_i) !(fifo_enq && fifo_full));
  assert property (@(posedge clk_i) disable iff (reset_i) !(resp_yumi_i && !resp_v_o));
  assert property (@(posedge clk_i) disable iff (reset_i)
                   !(dequeue && !issue && (outstanding_r == '0)));
  assert property (@(posedge clk_i) disable iff (reset_i)
                   !(cache_v_i && (outstanding_r == '0)));

endmodule

// File: tb/tb_bsg_manycore_cache_non_blocking_flow_ctrl.sv
// tb/tb_bsg_manycore_cache_non_blocking_flow_ctrl.sv - scoreboard bench for the cache flow controller

module tb_bsg_manycore_cache_non_blocking_flow_ctrl;

  localparam int DW  = 32;
  localparam int IW  = 14;
  localparam int PW  = 80;
  localparam int ELS = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [PW-1:0] req_pkt_i;
  logic          req_v_i;
  logic          req_ready_o;
  logic [PW-1:0] cache_pkt_o;
  logic          cache_v_o;
  logic          cache_ready_i;
  logic [DW-1:0] cache_data_i;
  logic [IW-1:0] cache_id_i;
  logic          cache_v_i;
  logic          cache_yumi_o;
  logic [DW-1:0] resp_data_o;
  logic [IW-1:0] resp_id_o;
  logic          resp_v_o;
  logic          resp_yumi_i;
  logic          yumi_en;

  logic [DW+IW-1:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  // Adapter only consumes a response that is actually presented.
  assign resp_yumi_i = yumi_en & resp_v_o;

  bsg_manycore_cache_non_blocking_flow_ctrl #(
    .data_width_p      (DW),
    .id_width_p        (IW),
    .cache_pkt_width_p (PW),
    .els_p             (ELS)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .req_pkt_i     (req_pkt_i),
    .req_v_i       (req_v_i),
    .req_ready_o   (req_ready_o),
    .cache_pkt_o   (cache_pkt_o),
    .cache_v_o     (cache_v_o),
    .cache_ready_i (cache_ready_i),
    .cache_data_i  (cache_data_i),
    .cache_id_i    (cache_id_i),
    .cache_v_i     (cache_v_i),
    .cache_yumi_o  (cache_yumi_o),
    .resp_data_o   (resp_data_o),
    .resp_id_o     (resp_id_o),
    .resp_v_o      (resp_v_o),
    .resp_yumi_i   (resp_yumi_i)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed response must match the oldest expected one.
  always @(negedge clk_i) begin
    if (!reset_i && resp_v_o && resp_yumi_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0h required=none", {resp_data_o, resp_id_o});
      end else begin
        logic [DW+IW-1:0] e;
        e = exp_q.pop_front();
        check("sb_resp", 64'({resp_data_o, resp_id_o}), 64'(e));
      end
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input int n);
    req_v_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      req_pkt_i = PW'(i * 3 + 1);
      #1;
      check("issue_ready", 64'(req_ready_o), 64'd1);
      check("issue_pkt", 64'(cache_pkt_o), 64'(i * 3 + 1));
      cycle();
    end
    req_v_i = 1'b0;
  endtask

  task automatic send_resp(input logic [DW-1:0] d, input logic [IW-1:0] id);
    cache_v_i    = 1'b1;
    cache_data_i = d;
    cache_id_i   = id;
    exp_q.push_back({d, id});
    #1;
    check("cache_yumi", 64'(cache_yumi_o), 64'd1);
    cycle();
    cache_v_i = 1'b0;
  endtask

  task automatic drain(input int n);
    yumi_en = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    yumi_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; req_v_i = 1'b0; req_pkt_i = '0; cache_ready_i = 1'b1;
    cache_v_i = 1'b0; cache_data_i = '0; cache_id_i = '0; yumi_en = 1'b0;
    cycle(); cycle();
    #1;
    check("rst_req_ready", 64'(req_ready_o), 64'd0);
    check("rst_resp_v", 64'(resp_v_o), 64'd0);
    check("rst_cache_yumi", 64'(cache_yumi_o), 64'd0);
    req_v_i = 1'b1;
    #1;
    check("rst_cache_v", 64'(cache_v_o), 64'd0);
    req_v_i = 1'b0;
    reset_i = 1'b0;
    cycle();
    check("rst_outstanding", 64'(dut.outstanding_r), 64'd0);

    // Three requests, three responses with 1-cycle delivery.
    issue(3);
    check("t1_outstanding3", 64'(dut.outstanding_r), 64'd3);
    yumi_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cache_v_i = 1'b1; cache_data_i = DW'(32'hA + k); cache_id_i = IW'(5 + k);
      exp_q.push_back({DW'(32'hA + k), IW'(5 + k)});
      #1;
      check("t1_cache_yumi", 64'(cache_yumi_o), 64'd1);
`ifndef BSG_MANYCORE_CACHE_FLOW_CTRL_BYPASS_EN
      check("t1_resp_v_same", 64'(resp_v_o), 64'd0);
`endif
      cycle();
      cache_v_i = 1'b0;
      #1;
`ifndef BSG_MANYCORE_CACHE_FLOW_CTRL_BYPASS_EN
      check("t1_resp_v_next", 64'(resp_v_o), 64'd1);
`endif
      cycle();
    end
    yumi_en = 1'b0;
    check("t1_outstanding0", 64'(dut.outstanding_r), 64'd0);

    // Fill all credits, return 8 responses without consuming.
    issue(8);
    check("t2_outstanding8", 64'(dut.outstanding_r), 64'd8);
    req_v_i = 1'b1;
    #1;
    check("t2_full_ready", 64'(req_ready_o), 64'd0);
    check("t2_full_cache_v", 64'(cache_v_o), 64'd0);
    req_v_i = 1'b0;
    for (int i = 0; i < 8; i++) send_resp(DW'(i), IW'(16 + i));
    check("t2_resp_v", 64'(resp_v_o), 64'd1);
    yumi_en = 1'b1;
    #1;
    check("t2_no_comb_credit", 64'(req_ready_o), 64'd0);
    cycle();
    yumi_en = 1'b0;
    #1;
    check("t2_credit_back", 64'(req_ready_o), 64'd1);
    check("t2_outstanding7", 64'(dut.outstanding_r), 64'd7);

    // Bring outstanding to 4, then issue and dequeue together.
    drain(3);
    check("t3_outstanding4", 64'(dut.outstanding_r), 64'd4);
    req_v_i = 1'b1; req_pkt_i = PW'(99); yumi_en = 1'b1;
    cycle();
    req_v_i = 1'b0; yumi_en = 1'b0;
    check("t3_outstanding_same", 64'(dut.outstanding_r), 64'd4);
    drain(3);
    check("t3_outstanding1", 64'(dut.outstanding_r), 64'd1);
    send_resp(DW'(8), IW'(24));
    drain(1);
    check("t3_outstanding0", 64'(dut.outstanding_r), 64'd0);

    // Refill across the pointer wrap: data 9..F follow 0..8 in order.
    issue(7);
    for (int i = 9; i < 16; i++) send_resp(DW'(i), IW'(16 + i));
    drain(7);
    check("t5_outstanding0", 64'(dut.outstanding_r), 64'd0);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // Cache not ready: no credit consumed, cache_v_o still follows req_v_i.
    cache_ready_i = 1'b0; req_v_i = 1'b1;
    #1;
    check("t4_req_ready", 64'(req_ready_o), 64'd0);
    check("t4_cache_v", 64'(cache_v_o), 64'd1);
    cycle();
    check("t4_outstanding", 64'(dut.outstanding_r), 64'd0);
    req_v_i = 1'b0; cache_ready_i = 1'b1;

    // Reset mid-operation drops credits and buffered responses.
    issue(5);
    send_resp(DW'(32'h55), IW'(1));
    send_resp(DW'(32'h66), IW'(2));
    reset_i = 1'b1;
    exp_q.delete();
    cycle();
    reset_i = 1'b0;
    #1;
    check("t6_resp_v", 64'(resp_v_o), 64'd0);
    check("t6_outstanding", 64'(dut.outstanding_r), 64'd0);
    issue(8);
    check("t6_outstanding8", 64'(dut.outstanding_r), 64'd8);

`ifdef BSG_MANYCORE_CACHE_FLOW_CTRL_BYPASS_EN
    yumi_en = 1'b1; cache_v_i = 1'b1;
    cache_data_i = DW'(32'h77); cache_id_i = IW'(14'h33);
    exp_q.push_back({DW'(32'h77), IW'(14'h33)});
    #1;
    check("byp_resp_v", 64'(resp_v_o), 64'd1);
    check("byp_resp_id", 64'(resp_id_o), 64'h33);
    check("byp_resp_data", 64'(resp_data_o), 64'h77);
    cycle();
    cache_v_i = 1'b0; yumi_en = 1'b0;
    check("byp_fifo_empty", 64'(dut.u_resp_fifo.empty_o), 64'd1);
    check("byp_outstanding7", 64'(dut.outstanding_r), 64'd7);
`endif

    cycle();
    check("end_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
